mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates an i-cache and a d-cache adapter onto one burst memory port.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on contention (default: d-cache wins).
module mem_port_arbiter #(
    parameter int BURST_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_mispredict,

    input  logic [31:0] ic_mem_addr,
    input  logic        ic_mem_read,
    input  logic        ic_mem_write,
    input  logic [63:0] ic_mem_wdata,
    output logic        ic_mem_ready,
    output logic [63:0] ic_mem_rdata,
    output logic [31:0] ic_mem_raddr,
    output logic        ic_mem_rvalid,

    input  logic [31:0] dc_mem_addr,
    input  logic        dc_mem_read,
    input  logic        dc_mem_write,
    input  logic [63:0] dc_mem_wdata,
    output logic        dc_mem_ready,
    output logic [63:0] dc_mem_rdata,
    output logic [31:0] dc_mem_raddr,
    output logic        dc_mem_rvalid,

    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata,
    input  logic [31:0] mem_raddr,
    input  logic        mem_rvalid,

    output logic        busy,
    output logic        owner
);

    localparam int CNT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic [31:0]      burst_addr_q, burst_addr_d;

    logic        ic_req, dc_req, win_dc, sel_dc;
    logic [31:0] src_addr;
    logic        src_read, src_write;
    logic [63:0] src_wdata;
    logic        beat_match, final_beat;

    // Read data and its address are broadcast; only rvalid is steered.
    assign ic_mem_rdata = mem_rdata;
    assign dc_mem_rdata = mem_rdata;
    assign ic_mem_raddr = mem_raddr;
    assign dc_mem_raddr = mem_raddr;
    assign owner        = owner_q;

    always_comb begin
        ic_req = ic_mem_read | ic_mem_write;
        dc_req = dc_mem_read | dc_mem_write;
`ifdef ARB_ROUND_ROBIN_EN
        win_dc = dc_req & (~ic_req | ~last_owner_q);
`else
        win_dc = dc_req;
`endif
        sel_dc     = (state_q == IDLE) ? win_dc : owner_q;
        src_addr   = sel_dc ? dc_mem_addr  : ic_mem_addr;
        src_read   = sel_dc ? dc_mem_read  : ic_mem_read;
        src_write  = sel_dc ? dc_mem_write : ic_mem_write;
        src_wdata  = sel_dc ? dc_mem_wdata : ic_mem_wdata;
        beat_match = mem_rvalid && (mem_raddr == burst_addr_q);
        final_beat = beat_match && (cnt_q == LAST_BEAT);
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        burst_addr_d  = burst_addr_q;
        mem_addr      = src_addr;
        mem_wdata     = src_wdata;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ic_mem_ready  = 1'b0;
        dc_mem_ready  = 1'b0;
        ic_mem_rvalid = 1'b0;
        dc_mem_rvalid = 1'b0;
        busy          = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if ((ic_req || dc_req) && !branch_mispredict) begin
                    mem_read     = src_read;
                    mem_write    = src_write;
                    ic_mem_ready = ~win_dc & mem_ready;
                    dc_mem_ready = win_dc & mem_ready;
                    if (mem_ready) begin
                        owner_d      = win_dc;
                        last_owner_d = win_dc;
                        burst_addr_d = src_addr;
                        if (src_write) begin
                            state_d = (BURST_BEATS == 1) ? IDLE : WRITE;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            state_d = READ;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            READ: begin
                ic_mem_rvalid = beat_match & ~owner_q;
                dc_mem_rvalid = beat_match & owner_q;
                if (final_beat) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (beat_match) cnt_d = cnt_q + CNT_W'(1);
                    if (branch_mispredict) state_d = DRAIN;
                end
            end
            WRITE: begin
                mem_read     = src_read;
                mem_write    = src_write;
                ic_mem_ready = ~owner_q & mem_ready;
                dc_mem_ready = owner_q & mem_ready;
                if (mem_write && mem_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (final_beat) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (beat_match) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset is synchronous, so the state can still read busy while rst is high; silence the port.
        if (rst) begin
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ic_mem_ready  = 1'b0;
            dc_mem_ready  = 1'b0;
            ic_mem_rvalid = 1'b0;
            dc_mem_rvalid = 1'b0;
            busy          = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            burst_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_addr_q <= burst_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter; expectations come from transaction-level rules.
module tb_mem_port_arbiter;

    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst, branch_mispredict;
    logic [31:0] ic_mem_addr, dc_mem_addr, mem_addr, mem_raddr;
    logic        ic_mem_read, ic_mem_write, dc_mem_read, dc_mem_write;
    logic [63:0] ic_mem_wdata, dc_mem_wdata, mem_wdata, mem_rdata;
    logic        ic_mem_ready, dc_mem_ready, ic_mem_rvalid, dc_mem_rvalid;
    logic [63:0] ic_mem_rdata, dc_mem_rdata;
    logic [31:0] ic_mem_raddr, dc_mem_raddr;
    logic        mem_read, mem_write, mem_ready, mem_rvalid;
    logic        busy, owner;

    mem_port_arbiter #(.BURST_BEATS(BEATS)) dut (
        .clk(clk), .rst(rst), .branch_mispredict(branch_mispredict),
        .ic_mem_addr(ic_mem_addr), .ic_mem_read(ic_mem_read), .ic_mem_write(ic_mem_write),
        .ic_mem_wdata(ic_mem_wdata), .ic_mem_ready(ic_mem_ready), .ic_mem_rdata(ic_mem_rdata),
        .ic_mem_raddr(ic_mem_raddr), .ic_mem_rvalid(ic_mem_rvalid),
        .dc_mem_addr(dc_mem_addr), .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
        .dc_mem_wdata(dc_mem_wdata), .dc_mem_ready(dc_mem_ready), .dc_mem_rdata(dc_mem_rdata),
        .dc_mem_raddr(dc_mem_raddr), .dc_mem_rvalid(dc_mem_rvalid),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_raddr(mem_raddr), .mem_rvalid(mem_rvalid),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;   // 0 = ic, 1 = dc
        bit          wr;
        logic [31:0] addr;
        logic [63:0] data;
    } ev_t;

    ev_t bus_q[$];   // expected memory-side handshakes (grants and write beats), in order
    ev_t rd_q[$];    // expected forwarded read beats, in order
    int  total = 0;
    int  bad   = 0;
    bit  last_owner_m = 1'b1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick_contended();
`ifdef ARB_ROUND_ROBIN_EN
        return !last_owner_m;
`else
        return 1'b1;
`endif
    endfunction

    task automatic set_port(input bit port, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [63:0] wd);
        if (port) begin
            dc_mem_read = rd; dc_mem_write = wr; dc_mem_addr = a; dc_mem_wdata = wd;
        end else begin
            ic_mem_read = rd; ic_mem_write = wr; ic_mem_addr = a; ic_mem_wdata = wd;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a handshake or a forwarded beat.
    always @(negedge clk) begin
        if (ic_mem_rvalid || dc_mem_rvalid) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rvalid_unexpected: ic=%0b dc=%0b raddr=%0h", ic_mem_rvalid, dc_mem_rvalid, mem_raddr);
            end else begin
                ev_t e;
                e = rd_q.pop_front();
                if ((ic_mem_rvalid && dc_mem_rvalid) || dc_mem_rvalid != e.port ||
                    (dc_mem_rvalid ? dc_mem_rdata : ic_mem_rdata) != e.data ||
                    (dc_mem_rvalid ? dc_mem_raddr : ic_mem_raddr) != e.addr) begin
                    bad++;
                    $display("FAIL rd_beat: got port=%0b data=%0h addr=%0h want port=%0b data=%0h addr=%0h",
                             dc_mem_rvalid, dc_mem_rvalid ? dc_mem_rdata : ic_mem_rdata, mem_raddr,
                             e.port, e.data, e.addr);
                end
            end
        end
        if (ic_mem_ready || dc_mem_ready || (mem_ready && (mem_read || mem_write))) begin
            total++;
            if (bus_q.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected: ic_rdy=%0b dc_rdy=%0b rd=%0b wr=%0b addr=%0h",
                         ic_mem_ready, dc_mem_ready, mem_read, mem_write, mem_addr);
            end else begin
                ev_t e;
                e = bus_q.pop_front();
                if (!(ic_mem_ready ^ dc_mem_ready) || dc_mem_ready != e.port || mem_write != e.wr ||
                    mem_read != !e.wr || mem_addr != e.addr || (e.wr && mem_wdata != e.data)) begin
                    bad++;
                    $display("FAIL bus_event: got ic_rdy=%0b dc_rdy=%0b wr=%0b rd=%0b addr=%0h wdata=%0h want port=%0b wr=%0b addr=%0h wdata=%0h",
                             ic_mem_ready, dc_mem_ready, mem_write, mem_read, mem_addr, mem_wdata,
                             e.port, e.wr, e.addr, e.data);
                end
            end
        end
    end

    task automatic wait_grant(input bit port);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((port ? dc_mem_ready : ic_mem_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: port=%0d never saw ready", port);
        end
        cyc();
    endtask

    // mp_k: 0 none, 1..BEATS-1 flush after that many beats, BEATS flush together with the last beat.
    task automatic run_read(input bit port, input logic [31:0] addr, input int n_bad, input int mp_k,
                            input int mp_req, input bit seq_data);
        int m, bad_left;
        bit fwd;
        logic [63:0] d;
        mem_ready = 1'b1;
        set_port(port, 1'b1, 1'b0, addr, '0);
        if (mp_req > 0) begin
            branch_mispredict = 1'b1;
            repeat (mp_req) begin
                #2;
                check("flush_idle_read", mem_read, 1'b0);
                check("flush_idle_ready", {ic_mem_ready, dc_mem_ready}, 2'b00);
                cyc();
            end
            branch_mispredict = 1'b0;
        end
        bus_q.push_back('{port, 1'b0, addr, 64'h0});
        wait_grant(port);
        set_port(port, 1'b0, 1'b0, addr, '0);
        check("owner_after_rd_grant", owner, port);
        last_owner_m = port;
        mem_ready = 1'($urandom_range(0, 1));
        m = 0; fwd = 1'b1; bad_left = n_bad;
        for (int c = 0; c < 200 && m < BEATS; c++) begin
            mem_rvalid = 1'b0;
            branch_mispredict = 1'b0;
            if (fwd && mp_k > 0 && mp_k < BEATS && m == mp_k) begin
                branch_mispredict = 1'b1;
                fwd = 1'b0;
            end else if (bad_left > 0 && $urandom_range(0, 1) == 1) begin
                mem_rvalid = 1'b1;
                mem_raddr  = addr + 32'h1000;
                mem_rdata  = {$urandom, $urandom};
                bad_left--;
            end else if ($urandom_range(0, 3) == 0) begin
                branch_mispredict = !fwd && ($urandom_range(0, 1) == 1);
            end else begin
                d = seq_data ? 64'(m + 1) : {$urandom, $urandom};
                mem_rvalid = 1'b1;
                mem_raddr  = addr;
                mem_rdata  = d;
                if (fwd) rd_q.push_back('{port, 1'b0, addr, d});
                if (m == BEATS - 1 && mp_k == BEATS) branch_mispredict = 1'b1;
                m++;
            end
            #2;
            check("busy_in_burst", busy, 1'b1);
            check("rdata_bcast", {ic_mem_rdata, dc_mem_rdata}, {mem_rdata, mem_rdata});
            cyc();
        end
        mem_rvalid = 1'b0;
        branch_mispredict = 1'b0;
        mem_ready = 1'b0;
        #2;
        check("busy_after_read", busy, 1'b0);
        cyc();
    endtask

    task automatic run_write(input bit port, input logic [31:0] addr, input int stall, input bit mp,
                             input bit pend, input logic [31:0] pend_addr);
        logic [63:0] d [BEATS];
        int beat, stalls;
        bit ok, granted;
        for (int i = 0; i < BEATS; i++) begin
            d[i] = {$urandom, $urandom};
            bus_q.push_back('{port, 1'b1, addr, d[i]});
        end
        set_port(port, 1'b0, 1'b1, addr, d[0]);
        mem_ready = 1'b1;
        beat = 0; stalls = 0; ok = 1'b0; granted = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if ((port ? dc_mem_ready : ic_mem_ready) === 1'b1) beat++;
            else if (beat > 0) check("write_held_in_stall", mem_write, 1'b1);
            cyc();
            if (beat > 0 && !granted) begin
                granted = 1'b1;
                check("owner_after_wr_grant", owner, port);
                last_owner_m = port;
                if (pend) set_port(!port, 1'b1, 1'b0, pend_addr, '0);
            end
            if (beat == BEATS) begin
                ok = 1'b1;
                break;
            end
            if (port) dc_mem_wdata = d[beat]; else ic_mem_wdata = d[beat];
            branch_mispredict = mp && ($urandom_range(0, 1) == 1);
            if (beat == 2 && stalls < stall) begin
                mem_ready = 1'b0;
                stalls++;
            end else begin
                mem_ready = 1'b1;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL write_timeout: port=%0d beats=%0d", port, beat);
        end
        if (port) begin dc_mem_write = 1'b0; end else begin ic_mem_write = 1'b0; end
        mem_ready = 1'b0;
        branch_mispredict = 1'b0;
        #2;
        check("busy_after_write", busy, 1'b0);
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        last_owner_m = 1'b1;
        cyc();
    endtask

    initial begin
        bit w, p;
        logic [31:0] a, a2;
        int op;
        rst = 1'b1; branch_mispredict = 1'b0;
        set_port(1'b0, 1'b1, 1'b0, 32'h0, '0);
        set_port(1'b1, 1'b0, 1'b0, 32'h0, '0);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_raddr = 32'h0; mem_rdata = 64'h55;
        repeat (2) cyc();
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_mem_rw", {mem_read, mem_write}, 2'b00);
        check("rst_ready", {ic_mem_ready, dc_mem_ready}, 2'b00);
        check("rst_rvalid", {ic_mem_rvalid, dc_mem_rvalid}, 2'b00);
        check("rst_owner", owner, 1'b0);
        cyc();
        ic_mem_read = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        rst = 1'b0;
        last_owner_m = 1'b1;
        #2;
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_owner", owner, 1'b0);
        cyc();

        run_read(1'b1, 32'h0000_1000, 0, 0, 0, 1'b1);

        do_reset();
        w = pick_contended();
        set_port(!w, 1'b1, 1'b0, w ? 32'h0000_1100 : 32'h0000_1200, '0);
        run_read(w, w ? 32'h0000_1200 : 32'h0000_1100, 0, 0, 0, 1'b0);
        run_read(!w, w ? 32'h0000_1100 : 32'h0000_1200, 0, 0, 0, 1'b0);

        run_write(1'b1, 32'h0000_2000, 2, 1'b0, 1'b1, 32'h0000_2400);
        run_read(1'b0, 32'h0000_2400, 0, 0, 0, 1'b0);

        run_read(1'b0, 32'h0000_3000, 0, 1, 0, 1'b0);
        run_write(1'b1, 32'h0000_3100, 0, 1'b1, 1'b0, 32'h0);
        run_read(1'b0, 32'h0000_3200, 0, BEATS, 0, 1'b0);
        run_read(1'b1, 32'h0000_3300, 0, 0, 2, 1'b0);
        run_read(1'b1, 32'h0000_4000, 2, 0, 0, 1'b0);

        // Reset in the middle of a read burst.
        dc_mem_read = 1'b1; dc_mem_addr = 32'h0000_4000; mem_ready = 1'b1;
        bus_q.push_back('{1'b1, 1'b0, 32'h0000_4000, 64'h0});
        wait_grant(1'b1);
        dc_mem_read = 1'b0; mem_ready = 1'b0; last_owner_m = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1; mem_raddr = 32'h0000_4000; mem_rdata = {$urandom, $urandom};
            rd_q.push_back('{1'b1, 1'b0, 32'h0000_4000, mem_rdata});
            cyc();
        end
        rst = 1'b1;
        mem_rdata = 64'hdead;
        #2;
        check("midrst_busy", busy, 1'b0);
        check("midrst_rvalid", {ic_mem_rvalid, dc_mem_rvalid}, 2'b00);
        cyc();
        rst = 1'b0; mem_rvalid = 1'b0;
        last_owner_m = 1'b1;
        #2;
        check("after_midrst_busy", busy, 1'b0);
        check("after_midrst_owner", owner, 1'b0);
        cyc();

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            p  = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFFF_FFE0;
            a2 = a ^ 32'h0001_0000;
            case (op)
                0: run_read(p, a, $urandom_range(0, 2),
                            ($urandom_range(0, 2) == 0) ? $urandom_range(1, BEATS) : 0,
                            $urandom_range(0, 1), 1'b0);
                1: run_write(p, a, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
                2: begin
                    w = pick_contended();
                    set_port(!w, 1'b1, 1'b0, a2, '0);
                    run_read(w, a, $urandom_range(0, 1), 0, 0, 1'b0);
                    run_read(!w, a2, 0, 0, 0, 1'b0);
                end
                default: begin
                    run_write(p, a, 1, 1'b0, 1'b1, a2);
                    run_read(!p, a2, 0, 0, 0, 1'b0);
                end
            endcase
        end

        repeat (3) cyc();
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        check("bus_q_drained", 64'(bus_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
